uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver with mid-bit sampling, framing-error and
//               break handling, feeding a show-ahead received-byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 174,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Counter counts down to zero; a sample is taken on the cycle it reads zero,
    // so loading N-1 places the sample N cycles after the load.
    localparam logic [c_CNT_W-1:0] c_HALF_LOAD = c_CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LOAD  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_PTR_W:0]   c_DEPTH     = (c_PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic               r_rx_meta;
    logic               r_rx_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_push;
    logic               w_push_nxt;
    logic               r_frame_err;
    logic               w_frame_err_nxt;
    logic               w_tick;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overrun;
    logic               w_do_pop;
    logic               w_do_push;
    logic               w_drop;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receiver FSM state, bit timer, bit index, shift register and event flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_push      <= w_push_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign w_tick = (r_cnt == '0);

    // Next-state logic: sample at mid-bit, shift LSB first, validate stop bit.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_push_nxt      = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = c_HALF_LOAD;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (!r_rx_s) begin
                        w_state_nxt   = S_DATA;
                        w_cnt_nxt     = c_BIT_LOAD;
                        w_bit_idx_nxt = '0;
                    end else begin
                        // Start bit did not persist to mid-bit: treat as glitch.
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_cnt_nxt   = c_BIT_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_push_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it cannot be re-read as new frames.
                w_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A pop frees a slot in the same cycle, so push-while-full with pop succeeds.
    assign w_do_pop  = rd_en && !empty;
    assign w_do_push = r_push && (!full || w_do_pop);
    assign w_drop    = r_push && full && !w_do_pop;

    // Storage array; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy and overrun pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end
        end
    end

    // Head byte is forced to zero while empty so reset shows 8'h00 immediately.
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_DEPTH);
    assign data      = empty ? 8'h00 : r_mem[r_rd_ptr];
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
